mem_port_arbiter: RTL and testbench

Arbitrates the single shared `Memory` port between the instruction-fetch unit and the load/store unit of the RV32IC core. It latches one request at a time and drives `memory_write`/`memory_data_in`/`memory_size`/`memory_addr` for exactly one access. It returns `memory_data_out` to the winning requester with a one-cycle valid pulse. Data accesses take priority; a starvation guard bounds fetch latency. Misaligned data accesses are trapped before they reach memory.

---
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single Memory port between instruction fetch and load/store.
//   One request is latched at a time and completes as a single memory access
//   followed by a one-cycle response pulse to the winning requester.
//   Data requests win arbitration unless fetch has been passed over
//   STARVE_LIMIT times in a row. Misaligned data requests skip memory and
//   respond with d_err.
//
// Ports
//   clk, rst (async, active-low)
//   if_req/if_addr -> if_gnt, if_rvalid, if_rdata       fetch side
//   d_req/d_we/d_addr/d_wdata/d_size -> d_gnt, d_rvalid, d_rdata, d_err
//   memory_write/memory_data_in/memory_size/memory_addr -> Memory
//   memory_data_out <- Memory (combinational read of memory_addr)
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        memory_write,
    output logic [31:0] memory_data_in,
    output logic [1:0]  memory_size,
    output logic [31:0] memory_addr,
    input  logic [31:0] memory_data_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_err_q, d_err_d;

    // Latched request fields; only observed while in ACCESS, so no reset.
    logic        sel_data_q, sel_data_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;

    logic fetch_wins;
    logic in_access;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return addr_lo[0];
            2'd2:    return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    // Fetch wins when it is alone or when data has starved it long enough.
    assign fetch_wins = if_req && (!d_req || starve_cnt_q == LIMIT);
    assign if_gnt     = (state_q == IDLE) && fetch_wins;
    assign d_gnt      = (state_q == IDLE) && d_req && !fetch_wins;

    assign in_access      = (state_q == ACCESS);
    assign memory_write   = in_access && sel_data_q && we_q;
    assign memory_data_in = (in_access && sel_data_q && we_q) ? wdata_q : 32'd0;
    assign memory_size    = (in_access && sel_data_q) ? size_q : 2'd2;
    assign memory_addr    = !in_access ? 32'd0 :
                            (sel_data_q ? addr_q : {addr_q[31:2], 2'b00});

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        if_rvalid_d  = if_rvalid_q;
        if_rdata_d   = if_rdata_q;
        d_rvalid_d   = d_rvalid_q;
        d_rdata_d    = d_rdata_q;
        d_err_d      = d_err_q;
        sel_data_d   = sel_data_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;

        case (state_q)
            IDLE: begin
                if (if_gnt) begin
                    sel_data_d   = 1'b0;
                    we_d         = 1'b0;
                    addr_d       = if_addr;
                    wdata_d      = 32'd0;
                    size_d       = 2'd2;
                    starve_cnt_d = 4'd0;
                    state_d      = ACCESS;
                end else if (d_gnt) begin
                    sel_data_d = 1'b1;
                    we_d       = d_we;
                    addr_d     = d_addr;
                    wdata_d    = d_wdata;
                    size_d     = d_size;
                    if (!if_req) begin
                        starve_cnt_d = 4'd0;
                    end else if (starve_cnt_q != LIMIT) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                    if (misaligned(d_size, d_addr[1:0])) begin
                        // Trap without touching memory; respond next cycle.
                        d_rvalid_d = 1'b1;
                        d_err_d    = 1'b1;
                        d_rdata_d  = 32'd0;
                        state_d    = RESP;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (sel_data_q) begin
                    d_rvalid_d = 1'b1;
                    d_err_d    = 1'b0;
                    d_rdata_d  = we_q ? 32'd0 : memory_data_out;
                end else begin
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = memory_data_out;
                end
            end
            RESP: begin
                if_rvalid_d = 1'b0;
                d_rvalid_d  = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= 4'd0;
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= 32'd0;
            d_rvalid_q   <= 1'b0;
            d_rdata_q    <= 32'd0;
            d_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            if_rvalid_q  <= if_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            d_rvalid_q   <= d_rvalid_d;
            d_rdata_q    <= d_rdata_d;
            d_err_q      <= d_err_d;
        end
    end

    always_ff @(posedge clk) begin
        sel_data_q <= sel_data_d;
        we_q       <= we_d;
        addr_q     <= addr_d;
        wdata_q    <= wdata_d;
        size_q     <= size_d;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter: reset values, load, store, fetch,
//   misaligned/illegal traps, starvation pattern and reset mid-access.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_size;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        memory_write;
    logic [31:0] memory_data_in;
    logic [1:0]  memory_size;
    logic [31:0] memory_addr;
    logic [31:0] memory_data_out;

    logic [31:0] mem [0:15];
    assign memory_data_out = mem[memory_addr[5:2]];

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_size(d_size), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .memory_write(memory_write), .memory_data_in(memory_data_in),
        .memory_size(memory_size), .memory_addr(memory_addr),
        .memory_data_out(memory_data_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one data request and follow it to its response pulse.
    // lat counts negedges after the grant edge until d_rvalid (-1 if none).
    task automatic data_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] size, output int gnt_wait, output int lat,
                            output logic err, output logic [31:0] rdata, output int wr_cycles);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_size = size;
        gnt_wait = 0; lat = -1; err = 1'b0; rdata = 32'd0; wr_cycles = 0;
        @(negedge clk);
        while (!d_gnt && gnt_wait < 20) begin
            @(negedge clk);
            gnt_wait++;
        end
        @(posedge clk); #1;
        d_req = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (memory_write) wr_cycles++;
            if (d_rvalid) begin
                lat   = c;
                err   = d_err;
                rdata = d_rdata;
                break;
            end
        end
    endtask

    // Trap table: size, addr, expected err, expected rdata (loads).
    logic [1:0]  tbl_size  [0:4] = '{2'd1, 2'd3, 2'd1, 2'd0, 2'd2};
    logic [31:0] tbl_addr  [0:4] = '{32'h3, 32'h0, 32'h2, 32'h3, 32'h8};
    logic        tbl_err   [0:4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] tbl_rdata [0:4] = '{32'h0, 32'h0, 32'hA5000000, 32'hA5000000, 32'hA5000002};

    int          gw, lat, wr, grants, cyc, last_gnt, rv_cnt;
    logic        err;
    logic [31:0] rd;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hA5000000 | 32'(i);
        mem[4] = 32'hDEADBEEF;
        mem[8] = 32'hCAFEF00D;

        rst = 1'b0; if_req = 1'b0; if_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; d_size = 2'd0;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_if_gnt",    32'(if_gnt), 32'd0);
        check_eq("rst_d_gnt",     32'(d_gnt), 32'd0);
        check_eq("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        check_eq("rst_if_rdata",  if_rdata, 32'd0);
        check_eq("rst_d_rvalid",  32'(d_rvalid), 32'd0);
        check_eq("rst_d_rdata",   d_rdata, 32'd0);
        check_eq("rst_d_err",     32'(d_err), 32'd0);
        check_eq("rst_mem_write", 32'(memory_write), 32'd0);
        check_eq("rst_mem_din",   memory_data_in, 32'd0);
        check_eq("rst_mem_size",  32'(memory_size), 32'd2);
        check_eq("rst_mem_addr",  memory_addr, 32'd0);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_eq("idle_no_gnt", 32'({if_gnt, d_gnt}), 32'd0);
        end

        // Single load: grant T, memory T+1, rvalid T+2
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_size = 2'd2;
        @(negedge clk);
        check_eq("ld_d_gnt", 32'(d_gnt), 32'd1);
        check_eq("ld_if_gnt", 32'(if_gnt), 32'd0);
        @(posedge clk); #1; d_req = 1'b0;
        @(negedge clk);
        check_eq("ld_mem_addr", memory_addr, 32'h10);
        check_eq("ld_mem_write", 32'(memory_write), 32'd0);
        check_eq("ld_mem_size", 32'(memory_size), 32'd2);
        check_eq("ld_rvalid_early", 32'(d_rvalid), 32'd0);
        check_eq("ld_no_regrant", 32'(d_gnt), 32'd0);
        @(negedge clk);
        check_eq("ld_rvalid", 32'(d_rvalid), 32'd1);
        check_eq("ld_rdata", d_rdata, 32'hDEADBEEF);
        check_eq("ld_err", 32'(d_err), 32'd0);
        @(negedge clk);
        check_eq("ld_rvalid_pulse", 32'(d_rvalid), 32'd0);
        check_eq("ld_rdata_hold", d_rdata, 32'hDEADBEEF);

        // Store byte
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h4; d_wdata = 32'd10; d_size = 2'd0;
        @(negedge clk);
        check_eq("st_d_gnt", 32'(d_gnt), 32'd1);
        @(posedge clk); #1; d_req = 1'b0;
        @(negedge clk);
        check_eq("st_mem_write", 32'(memory_write), 32'd1);
        check_eq("st_mem_din", memory_data_in, 32'd10);
        check_eq("st_mem_size", 32'(memory_size), 32'd0);
        check_eq("st_mem_addr", memory_addr, 32'h4);
        @(negedge clk);
        check_eq("st_mem_write_off", 32'(memory_write), 32'd0);
        check_eq("st_rvalid", 32'(d_rvalid), 32'd1);
        check_eq("st_rdata", d_rdata, 32'd0);
        check_eq("st_err", 32'(d_err), 32'd0);
        d_we = 1'b0;

        // Misaligned word store: trap in one cycle, no memory write
        data_txn(1'b1, 32'h6, 32'h12345678, 2'd2, gw, lat, err, rd, wr);
        check_eq("mis_gnt_wait", 32'(gw), 32'd0);
        check_eq("mis_latency", 32'(lat), 32'd1);
        check_eq("mis_err", 32'(err), 32'd1);
        check_eq("mis_rdata", rd, 32'd0);
        check_eq("mis_no_write", 32'(wr), 32'd0);
        @(negedge clk);
        check_eq("mis_rvalid_pulse", 32'(d_rvalid), 32'd0);

        // Alignment / size table (loads)
        for (int k = 0; k < 5; k++) begin
            data_txn(1'b0, tbl_addr[k], 32'd0, tbl_size[k], gw, lat, err, rd, wr);
            check_eq($sformatf("tbl%0d_gnt", k), 32'(gw), 32'd0);
            check_eq($sformatf("tbl%0d_lat", k), 32'(lat), tbl_err[k] ? 32'd1 : 32'd2);
            check_eq($sformatf("tbl%0d_err", k), 32'(err), 32'(tbl_err[k]));
            check_eq($sformatf("tbl%0d_rdata", k), rd, tbl_rdata[k]);
        end

        // Fetch: word-aligned address, size 2, no write
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h23;
        @(negedge clk);
        check_eq("f_if_gnt", 32'(if_gnt), 32'd1);
        check_eq("f_d_gnt", 32'(d_gnt), 32'd0);
        @(posedge clk); #1; if_req = 1'b0;
        @(negedge clk);
        check_eq("f_mem_addr", memory_addr, 32'h20);
        check_eq("f_mem_size", 32'(memory_size), 32'd2);
        check_eq("f_mem_write", 32'(memory_write), 32'd0);
        @(negedge clk);
        check_eq("f_rvalid", 32'(if_rvalid), 32'd1);
        check_eq("f_rdata", if_rdata, 32'hCAFEF00D);
        check_eq("f_d_rvalid", 32'(d_rvalid), 32'd0);
        @(negedge clk);
        check_eq("f_rvalid_pulse", 32'(if_rvalid), 32'd0);

        // Starvation: both held high, expect D,D,D,D,F repeating, 3-cycle spacing
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_size = 2'd2;
        grants = 0; cyc = 0; last_gnt = -1;
        while (grants < 10 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            check_eq("gnt_exclusive", 32'(if_gnt & d_gnt), 32'd0);
            if (if_gnt || d_gnt) begin
                check_eq($sformatf("starve_seq%0d", grants), 32'(if_gnt), (grants % 5 == 4) ? 32'd1 : 32'd0);
                if (last_gnt >= 0) check_eq($sformatf("starve_gap%0d", grants), 32'(cyc - last_gnt), 32'd3);
                last_gnt = cyc;
                grants++;
            end
        end
        check_eq("starve_grants", 32'(grants), 32'd10);
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during ACCESS of a store
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'h55; d_size = 2'd2;
        @(negedge clk);
        check_eq("rm_d_gnt", 32'(d_gnt), 32'd1);
        @(posedge clk); #1; d_req = 1'b0;
        @(negedge clk);
        check_eq("rm_mem_write_pre", 32'(memory_write), 32'd1);
        #1 rst = 1'b0;
        #1;
        check_eq("rm_mem_write", 32'(memory_write), 32'd0);
        check_eq("rm_mem_addr", memory_addr, 32'd0);
        check_eq("rm_mem_size", 32'(memory_size), 32'd2);
        rv_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (d_rvalid) rv_cnt++;
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (d_rvalid) rv_cnt++;
        end
        check_eq("rm_no_rvalid", 32'(rv_cnt), 32'd0);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_size = 2'd2;
        @(negedge clk);
        check_eq("rm_idle_gnt", 32'(d_gnt), 32'd1);
        @(posedge clk); #1; d_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
